alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/full_adder.sv | 15 +
 rtl/muldiv_iter.sv | 102 ++++++++++
 rtl/alu_muldiv.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_muldiv block.
// Holds the 4-bit operation codes, the IDLE/BUSY/DONE controller state
// encoding and small opcode-classification helpers. No ports.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_BGE   = 4'b1011;
  localparam logic [3:0] OP_BGEU  = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multi-cycle operations handled by the iterative datapath.
  function automatic logic is_iter_op(input logic [3:0] ope);
    case (ope)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: is_iter_op = 1'b1;
      default:                            is_iter_op = 1'b0;
    endcase
  endfunction

  // Divider (DIVU/REMU) as opposed to multiplier (MUL/MULHU).
  function automatic logic is_div_op(input logic [3:0] ope);
    case (ope)
      OP_DIVU, OP_REMU: is_div_op = 1'b1;
      default:          is_div_op = 1'b0;
    endcase
  endfunction

  // Result taken from the accumulator half (MULHU high word, REMU remainder).
  function automatic logic is_hi_op(input logic [3:0] ope);
    case (ope)
      OP_MULHU, OP_REMU: is_hi_op = 1'b1;
      default:           is_hi_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/full_adder.sv
// N-bit full adder used for ADD and SUB.
// Ports: a_i, b_i (width) addends, cin_i carry-in, sum_o (width) sum.
// The carry-out is not exposed: all results are taken modulo 2^width.
module full_adder #(
  parameter int width = 64
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             cin_i,
  output logic [width-1:0] sum_o
);

  assign sum_o = a_i + b_i + {{(width-1){1'b0}}, cin_i};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 datapath: shift-add multiplier and restoring divider.
// Ports: clk_i, rst_i (sync, active-high); start_i loads operands and opcode;
// step_i performs one radix-2 step; op_i opcode at start; op1_i/op2_i operands;
// last_o marks the final step; res_o is the result produced by that final step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [width-1:0] op1_i,
  input  logic [width-1:0] op2_i,
  output logic             last_o,
  output logic [width-1:0] res_o
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

  // acc: product high word / partial remainder.
  // mq : multiplier shifting out, product low word shifting in / dividend -> quotient.
  // dsr: multiplicand or divisor.
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] mq_q, mq_d;
  logic [width-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             hi_q, hi_d;

  logic [width:0]   mul_sum;
  logic [width:0]   rem_shift;
  logic [width:0]   rem_diff;

  // Next-state computation for one multiply or divide step.
  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    div_d = div_q;
    hi_d  = hi_q;

    mul_sum   = {1'b0, acc_q} + {1'b0, dsr_q & {width{mq_q[0]}}};
    rem_shift = {acc_q, mq_q[width-1]};
    // The partial remainder stays below the divisor, so bit width of the
    // difference is a clean borrow; with a zero divisor it never borrows,
    // which yields an all-ones quotient and the dividend as remainder.
    rem_diff  = rem_shift - {1'b0, dsr_q};

    if (start_i) begin
      acc_d = {width{1'b0}};
      mq_d  = op1_i;
      dsr_d = op2_i;
      cnt_d = {CW{1'b0}};
      div_d = is_div_op(op_i);
      hi_d  = is_hi_op(op_i);
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        if (rem_diff[width]) begin
          acc_d = rem_shift[width-1:0];
          mq_d  = {mq_q[width-2:0], 1'b0};
        end else begin
          acc_d = rem_diff[width-1:0];
          mq_d  = {mq_q[width-2:0], 1'b1};
        end
      end else begin
        acc_d = mul_sum[width:1];
        mq_d  = {mul_sum[0], mq_q[width-1:1]};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and step-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= {width{1'b0}};
      mq_q  <= {width{1'b0}};
      dsr_q <= {width{1'b0}};
      cnt_q <= {CW{1'b0}};
      div_q <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      hi_q  <= hi_d;
    end
  end

  assign last_o = step_i && (cnt_q == CNT_LAST);
  assign res_o  = hi_q ? acc_d : mq_d;

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle integer ops and iterative MUL/MULHU/DIVU/REMU.
// Ports: clk_i, rst_i (sync, active-high); valid_i/ready_o request handshake;
// op1_i, op2_i (width) operands; ope_i (4) opcode; valid_o one-cycle result
// pulse; res_o (width) registered result; b_flag_o registered branch flag.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [width-1:0] op1_i,
  input  logic [width-1:0] op2_i,
  input  logic [3:0]       ope_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [width-1:0] res_o,
  output logic             b_flag_o
);

  localparam int SHW = $clog2(width);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             b_flag_q, b_flag_d;
  logic [width-1:0] res_q, res_d;

  logic             accept;
  logic             iter_op;
  logic             is_sub;
  logic             lt_s;
  logic             lt_u;
  logic             alu_flag;
  logic             md_last;
  logic [SHW-1:0]   shamt;
  logic [width-1:0] add_b;
  logic [width-1:0] add_sum;
  logic [width-1:0] alu_res;
  logic [width-1:0] md_res;

  assign ready_o  = (state_q != BUSY);
  assign accept   = valid_i && ready_o;
  assign iter_op  = is_iter_op(ope_i);
  assign is_sub   = (ope_i == OP_SUB);
  assign add_b    = is_sub ? ~op2_i : op2_i;
  assign shamt    = op2_i[SHW-1:0];
  assign lt_s     = $signed(op1_i) < $signed(op2_i);
  assign lt_u     = op1_i < op2_i;

  full_adder #(.width(width)) u_add (
    .a_i   (op1_i),
    .b_i   (add_b),
    .cin_i (is_sub),
    .sum_o (add_sum)
  );

  muldiv_iter #(.width(width)) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (accept && iter_op),
    .step_i  (state_q == BUSY),
    .op_i    (ope_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .last_o  (md_last),
    .res_o   (md_res)
  );

  // Single-cycle result and branch flag, computed from the accepted request.
  always_comb begin
    alu_res  = {width{1'b0}};
    alu_flag = 1'b0;
    case (ope_i)
      OP_ADD, OP_SUB:   alu_res = add_sum;
      OP_SLL:           alu_res = op1_i << shamt;
      OP_SRL:           alu_res = op1_i >> shamt;
      OP_SRA:           alu_res = $unsigned($signed(op1_i) >>> shamt);
      OP_SLT, OP_BGE:   alu_res = {{(width-1){1'b0}}, lt_s};
      OP_SLTU, OP_BGEU: alu_res = {{(width-1){1'b0}}, lt_u};
      OP_XOR:           alu_res = op1_i ^ op2_i;
      OP_OR:            alu_res = op1_i | op2_i;
      OP_AND:           alu_res = op1_i & op2_i;
      default:          alu_res = {width{1'b0}};
    endcase
    case (ope_i)
      OP_SUB:  alu_flag = (alu_res != {width{1'b0}});
      OP_XOR:  alu_flag = (alu_res == {width{1'b0}});
      OP_SLT:  alu_flag = lt_s;
      OP_SLTU: alu_flag = lt_u;
      OP_BGE:  alu_flag = !lt_s;
      OP_BGEU: alu_flag = !lt_u;
      default: alu_flag = 1'b0;
    endcase
  end

  // Controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept && iter_op) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (md_last) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register next values; res/b_flag hold until a new result lands.
  always_comb begin
    valid_d  = 1'b0;
    res_d    = res_q;
    b_flag_d = b_flag_q;
    if (state_q == BUSY) begin
      if (md_last) begin
        valid_d  = 1'b1;
        res_d    = md_res;
        b_flag_d = 1'b0;
      end else begin
        valid_d  = 1'b0;
      end
    end else if (accept && !iter_op) begin
      valid_d  = 1'b1;
      res_d    = alu_res;
      b_flag_d = alu_flag;
    end else begin
      valid_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      res_q    <= {width{1'b0}};
      b_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      b_flag_q <= b_flag_d;
    end
  end

  assign valid_o  = valid_q;
  assign res_o    = res_q;
  assign b_flag_o = b_flag_q;

endmodule
